// File: rtl/gpu_rect_engine_if.sv
// Rectangle engine op/sprite/framebuffer bus and the shared op bundle type.
// The pix_count signal exists only when GPU_STATS_EN is defined.
package gpu_pkg;
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] width;
    logic [10:0] height;
    logic        color;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        scale;
  } gpu_op_t;
endpackage

interface gpu_rect_engine_if #(
  parameter int SPR_ADDR_W = 16
);
  import gpu_pkg::*;

  gpu_op_t                 op;
  logic                    op_valid;
  logic                    op_ready;
  logic [SPR_ADDR_W-1:0]   spr_addr;
  logic [1:0]              spr_data;
  logic                    fb_we;
  logic [10:0]             fb_x;
  logic [10:0]             fb_y;
  logic                    fb_color;
  logic                    fb_ready;
`ifdef GPU_STATS_EN
  logic [31:0]             pix_count;
`endif

  modport master (
    output op, op_valid, spr_data, fb_ready,
    input  op_ready, spr_addr, fb_we, fb_x, fb_y, fb_color
`ifdef GPU_STATS_EN
    , input pix_count
`endif
  );

  modport slave (
    input  op, op_valid, spr_data, fb_ready,
    output op_ready, spr_addr, fb_we, fb_x, fb_y, fb_color
`ifdef GPU_STATS_EN
    , output pix_count
`endif
  );
endinterface

// File: rtl/gpu_rect_engine.sv
// Rasterises fill / sprite rectangle ops into framebuffer writes.
// Optional macro GPU_STATS_EN adds a saturating accepted-write counter.
module gpu_rect_engine
  import gpu_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int SPR_ADDR_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  gpu_rect_engine_if.slave   bus
);

  localparam logic [11:0] HMAX = 12'(HOR_ACTIVE_PIXELS);
  localparam logic [11:0] VMAX = 12'(VER_ACTIVE_PIXELS);

  typedef enum logic [2:0] {
    IDLE, FILL, SPR_FETCH, SPR_WRITE, DONE
  } state_t;

  state_t                state_q;
  gpu_op_t               op_q;
  logic [10:0]           dx_q, dy_q;
  logic                  op_ready_q;
  logic                  fb_we_q;
  logic [10:0]           fb_x_q, fb_y_q;
  logic                  fb_color_q;
  logic [SPR_ADDR_W-1:0] spr_addr_q;

  logic                  stall;
  logic                  last_x, last_y;
  logic [10:0]           nx, ny;
  logic [11:0]           px, py;
  logic                  in_view;
  logic                  pix_wr, pix_col;
  logic [10:0]           stride, sx, sy;
  logic [SPR_ADDR_W-1:0] nxt_addr;

  always_comb begin
    stall   = fb_we_q & ~bus.fb_ready;
    last_x  = dx_q == op_q.width - 11'd1;
    last_y  = dy_q == op_q.height - 11'd1;
    nx      = last_x ? 11'd0 : dx_q + 11'd1;
    ny      = last_x ? dy_q + 11'd1 : dy_q;
    px      = {1'b0, op_q.x} + {1'b0, dx_q};
    py      = {1'b0, op_q.y} + {1'b0, dy_q};
    in_view = (px < HMAX) && (py < VMAX);
    pix_wr  = op_q.mem_en ? bus.spr_data[1] : 1'b1;
    pix_col = op_q.mem_en ? bus.spr_data[0] : op_q.color;
    // address of the pixel after the current one, fetched next
    stride  = op_q.width >> op_q.scale;
    sx      = nx >> op_q.scale;
    sy      = ny >> op_q.scale;
    nxt_addr = SPR_ADDR_W'(op_q.mem_addr)
             + SPR_ADDR_W'(sy) * SPR_ADDR_W'(stride)
             + SPR_ADDR_W'(sx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      op_ready_q <= 1'b1;
      fb_we_q    <= 1'b0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      fb_color_q <= 1'b0;
      spr_addr_q <= '0;
    end else if (ce && !stall) begin
      fb_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.op_valid) begin
            op_q       <= bus.op;
            dx_q       <= '0;
            dy_q       <= '0;
            op_ready_q <= 1'b0;
            spr_addr_q <= SPR_ADDR_W'(bus.op.mem_addr);
            if (bus.op.width == '0 || bus.op.height == '0)
              state_q <= DONE;
            else if (bus.op.mem_en)
              state_q <= SPR_FETCH;
            else
              state_q <= FILL;
          end
        end
        FILL, SPR_WRITE: begin
          if (pix_wr && in_view) begin
            fb_we_q    <= 1'b1;
            fb_x_q     <= px[10:0];
            fb_y_q     <= py[10:0];
            fb_color_q <= pix_col;
          end
          dx_q <= nx;
          dy_q <= ny;
          if (op_q.mem_en)
            spr_addr_q <= nxt_addr;
          if (last_x && last_y)
            state_q <= DONE;
          else if (op_q.mem_en)
            state_q <= SPR_FETCH;
        end
        SPR_FETCH: state_q <= SPR_WRITE;
        DONE: begin
          op_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.op_ready = op_ready_q;
  assign bus.spr_addr = spr_addr_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_x     = fb_x_q;
  assign bus.fb_y     = fb_y_q;
  assign bus.fb_color = fb_color_q;

`ifdef GPU_STATS_EN
  logic [31:0] pix_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pix_count_q <= '0;
    else if (ce && fb_we_q && bus.fb_ready && pix_count_q != '1)
      pix_count_q <= pix_count_q + 32'd1;
  end

  assign bus.pix_count = pix_count_q;
`endif

endmodule

// File: tb/tb_gpu_rect_engine.sv
// Scoreboard bench for gpu_rect_engine: expected writes and sprite
// addresses are queued from a bench model and popped as the DUT emits.
module tb_gpu_rect_engine;
  import gpu_pkg::*;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        c;
  } wr_t;

  logic clk;
  logic rst;
  logic ce;
  int   checks;
  int   errors;
  wr_t         exp_q[$];
  logic [15:0] spr_q[$];
  wr_t         mon_e;

  gpu_rect_engine_if #(.SPR_ADDR_W(16)) bus ();

  gpu_rect_engine #(
    .HOR_ACTIVE_PIXELS(640),
    .VER_ACTIVE_PIXELS(480),
    .SPR_ADDR_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] rom_f(input logic [15:0] a);
    return {~a[0], a[1]};
  endfunction

  always @(posedge clk) bus.spr_data <= rom_f(bus.spr_addr);

  always @(negedge clk) begin
    if (rst && ce && bus.fb_we && bus.fb_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got (%0d,%0d) want none",
                 bus.fb_x, bus.fb_y);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.fb_x, bus.fb_y, bus.fb_color} !== mon_e) begin
          errors++;
          $display("FAIL write: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   bus.fb_x, bus.fb_y, bus.fb_color,
                   mon_e.x, mon_e.y, mon_e.c);
        end
      end
    end
  end

  function automatic gpu_op_t mk_op(int x, int y, int w, int h,
                                    bit c, bit m, int a, bit s);
    gpu_op_t o;
    o.x        = 11'(x);
    o.y        = 11'(y);
    o.width    = 11'(w);
    o.height   = 11'(h);
    o.color    = c;
    o.mem_en   = m;
    o.mem_addr = 16'(a);
    o.scale    = s;
    return o;
  endfunction

  task automatic push_model(input gpu_op_t o);
    int px, py, sx, sy, st;
    logic [15:0] a;
    logic [1:0]  d;
    bit wr, col;
    for (int dy = 0; dy < int'(o.height); dy++) begin
      for (int dx = 0; dx < int'(o.width); dx++) begin
        px = int'(o.x) + dx;
        py = int'(o.y) + dy;
        if (o.mem_en) begin
          st = int'(o.width) >> o.scale;
          sx = dx >> o.scale;
          sy = dy >> o.scale;
          a  = 16'(int'(o.mem_addr) + sy * st + sx);
          spr_q.push_back(a);
          d   = rom_f(a);
          wr  = d[1];
          col = d[0];
        end else begin
          wr  = 1'b1;
          col = o.color;
        end
        if (wr && px < 640 && py < 480)
          exp_q.push_back({11'(px), 11'(py), col});
      end
    end
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    ce           = 1'b1;
    bus.fb_ready = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = '0;
    exp_q.delete();
    spr_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_op(input gpu_op_t o, input int exp_lat,
                        input int ce_gap, input bit busy_pulse,
                        input string name);
    int n;
    logic [15:0] ea;
    push_model(o);
    @(negedge clk);
    checks++;
    if (bus.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before: got %0b want 1", name, bus.op_ready);
    end
    bus.op       = o;
    bus.op_valid = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b0;
    if (ce_gap > 0) ce = 1'b0;
    checks++;
    if (bus.op_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: got op_ready %0b want 0", name, bus.op_ready);
    end
    n = 0;
    while (bus.op_ready !== 1'b1 && n < 20000) begin
      if (o.mem_en && ce_gap == 0 && n % 2 == 0 && spr_q.size() > 0) begin
        ea = spr_q.pop_front();
        checks++;
        if (bus.spr_addr !== ea) begin
          errors++;
          $display("FAIL %s_spr_addr: got %0d want %0d",
                   name, bus.spr_addr, ea);
        end
      end
      if (ce_gap > 0 && n == ce_gap) begin
        checks++;
        if (bus.fb_we !== 1'b0 || bus.op_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_ce_hold: got we=%0b rdy=%0b want 0 0",
                   name, bus.fb_we, bus.op_ready);
        end
        ce = 1'b1;
      end
      if (busy_pulse && n == 2) begin
        bus.op       = mk_op(300, 300, 5, 5, 1'b1, 1'b0, 0, 1'b0);
        bus.op_valid = 1'b1;
      end
      if (busy_pulse && n == 3) bus.op_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, n, exp_lat);
    end
    checks++;
    if (exp_q.size() != 0 || spr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d writes %0d addrs want 0 0",
               name, exp_q.size(), spr_q.size());
      exp_q.delete();
      spr_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.op_ready !== 1'b1) begin
      errors++; $display("FAIL rst_op_ready: got %0b want 1", bus.op_ready);
    end
    checks++;
    if (bus.fb_we !== 1'b0) begin
      errors++; $display("FAIL rst_fb_we: got %0b want 0", bus.fb_we);
    end
    checks++;
    if (bus.fb_x !== 11'd0 || bus.fb_y !== 11'd0) begin
      errors++;
      $display("FAIL rst_fb_xy: got %0d,%0d want 0,0", bus.fb_x, bus.fb_y);
    end
    checks++;
    if (bus.fb_color !== 1'b0) begin
      errors++; $display("FAIL rst_fb_color: got %0b want 0", bus.fb_color);
    end
    checks++;
    if (bus.spr_addr !== 16'd0) begin
      errors++; $display("FAIL rst_spr_addr: got %0d want 0", bus.spr_addr);
    end
  endtask

  task automatic test_fill();
    run_op(mk_op(10, 20, 3, 2, 1'b1, 1'b0, 0, 1'b0), 7, 0, 1'b1, "fill");
  endtask

  task automatic test_clip();
    run_op(mk_op(638, 479, 4, 2, 1'b1, 1'b0, 0, 1'b0), 9, 0, 1'b0, "clip");
  endtask

  task automatic test_sprite();
    run_op(mk_op(50, 60, 4, 2, 1'b0, 1'b1, 100, 1'b1), 17, 0, 1'b0, "spr2x");
    run_op(mk_op(7, 9, 3, 2, 1'b0, 1'b1, 200, 1'b0), 13, 0, 1'b0, "spr1x");
    run_op(mk_op(2040, 5, 2, 1, 1'b0, 1'b1, 65534, 1'b0), 5, 0, 1'b0,
           "spr_wrap");
  endtask

  task automatic test_zero();
    run_op(mk_op(1, 1, 0, 4, 1'b1, 1'b0, 0, 1'b0), 1, 0, 1'b0, "zero_w");
    run_op(mk_op(1, 1, 4, 0, 1'b1, 1'b1, 0, 1'b0), 1, 0, 1'b0, "zero_h");
  endtask

  task automatic test_ce();
    run_op(mk_op(3, 4, 2, 1, 1'b0, 1'b0, 0, 1'b0), 6, 3, 1'b0, "ce_gap");
  endtask

  task automatic test_stall();
    int n;
    push_model(mk_op(5, 7, 1, 1, 1'b1, 1'b0, 0, 1'b0));
    bus.fb_ready = 1'b0;
    @(negedge clk);
    bus.op       = mk_op(5, 7, 1, 1, 1'b1, 1'b0, 0, 1'b0);
    bus.op_valid = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.fb_we !== 1'b1 || bus.fb_x !== 11'd5 || bus.fb_y !== 11'd7) begin
        errors++;
        $display("FAIL stall_hold%0d: got we=%0b (%0d,%0d) want 1 (5,7)",
                 i, bus.fb_we, bus.fb_x, bus.fb_y);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.fb_ready = 1'b1;
    n = 0;
    while (bus.op_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_done: got wait %0d left %0d want <100 0",
               n, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    gpu_op_t o;
    o = mk_op(0, 0, 100, 100, 1'b1, 1'b0, 0, 1'b0);
    push_model(o);
    @(negedge clk);
    bus.op       = o;
    bus.op_valid = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.fb_we !== 1'b0 || bus.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got we=%0b rdy=%0b want 0 1",
               bus.fb_we, bus.op_ready);
    end
    checks++;
    if (bus.fb_x !== 11'd0 || bus.fb_y !== 11'd0) begin
      errors++;
      $display("FAIL rst_mid_xy: got %0d,%0d want 0,0", bus.fb_x, bus.fb_y);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (bus.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_idle: got %0b want 1", bus.op_ready);
    end
    run_op(mk_op(1, 1, 2, 2, 1'b0, 1'b0, 0, 1'b0), 5, 0, 1'b0, "post_rst");
  endtask

  task automatic test_back_to_back();
    run_op(mk_op(100, 100, 2, 1, 1'b1, 1'b0, 0, 1'b0), 3, 0, 1'b0, "b2b_a");
    run_op(mk_op(200, 50, 1, 2, 1'b0, 1'b0, 0, 1'b0), 3, 0, 1'b0, "b2b_b");
  endtask

`ifdef GPU_STATS_EN
  task automatic test_stats();
    do_reset();
    run_op(mk_op(0, 0, 3, 2, 1'b1, 1'b0, 0, 1'b0), 7, 0, 1'b0, "st_fill");
    run_op(mk_op(0, 0, 1, 1, 1'b0, 1'b1, 101, 1'b0), 3, 0, 1'b0, "st_spr");
    checks++;
    if (bus.pix_count !== 32'd6) begin
      errors++;
      $display("FAIL pix_count: got %0d want 6", bus.pix_count);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_clip();
    test_sprite();
    test_zero();
    test_ce();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef GPU_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
